dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Two-master arbiter for the single DRAM controller request port (24-bit word address, 32-bit data, level request, one-cycle completion pulse).
- Master 0 is the CPU/cache fill path; master 1 is the DMA engine.
- One transaction is outstanding at a time. Address, data and direction are latched at grant and held stable to the DRAM controller until it completes.
- The completion pulse and read data are steered back to the owning master only.

Parameters:
- ADDR_WIDTH, 24, DRAM word-address width.
- DATA_WIDTH, 32, DRAM data width.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
- mN_addr  in  ADDR_WIDTH  master N address (N = 0, 1)
- mN_data_out  in  DATA_WIDTH  master N write data
- mN_req_read  in  1  master N read request, level
- mN_req_write  in  1  master N write request, level
- mN_data_in  out  DATA_WIDTH  read data to master N
- mN_data_valid  out  1  read-complete pulse to master N
- mN_write_complete  out  1  write-complete pulse to master N
- dram_addr  out  ADDR_WIDTH  latched address to DRAM controller
- dram_data_out  out  DATA_WIDTH  latched write data
- dram_req_read  out  1  read request to DRAM controller
- dram_req_write  out  1  write request to DRAM controller
- dram_data_in  in  DATA_WIDTH  read data from DRAM controller
- dram_data_valid  in  1  read-complete pulse
- dram_write_complete  in  1  write-complete pulse
- grant  out  2  one-hot current owner; 00 when idle
- arb_busy  out  1  1 while a transaction is outstanding

Behaviour:
- States:
  - IDLE: no owner.
  - BUSY: owner register owner ∈ {0, 1}, direction flag is_read.
- Reset (rst == 0 at posedge) sets:
  - state = IDLE; grant = 00; arb_busy = 0.
  - dram_req_read = dram_req_write = 0; dram_addr = 0; dram_data_out = 0.
  - last_owner = 1.
- Master request: mN_req = mN_req_read | mN_req_write. If both read and write are high, the transaction is a read.
- IDLE → BUSY at a posedge where any mN_req = 1. On that edge the arbiter:
  - selects the winner;
  - registers dram_addr and dram_data_out from the winner;
  - sets is_read;
  - asserts dram_req_read or dram_req_write (registered);
  - sets grant and arb_busy, and updates last_owner = winner.
  - Latency: request sampled at edge k, DRAM request visible after edge k.
- BUSY:
  - dram_req_*, dram_addr, dram_data_out and grant are held constant. Master inputs are ignored, including a deasserted owner request.
- BUSY → IDLE at a posedge where the matching completion is high:
  - dram_data_valid when is_read;
  - dram_write_complete when !is_read.
  - On that edge dram_req_*, grant and arb_busy clear. IDLE always lasts at least one cycle, so the DRAM controller sees its request deassert between transactions. Back-to-back transactions therefore cost a minimum of one idle cycle.
- Completion routing is combinational:
  - mN_data_valid = dram_data_valid & is_read & BUSY & owner == N.
  - mN_write_complete = dram_write_complete & !is_read & BUSY & owner == N.
  - mN_data_in = dram_data_in for both masters, unqualified; masters sample only on their own data_valid.
- Requester contract: a master holds its request until it sees its completion pulse, and drops it on that same edge. A request still high in IDLE is treated as a new transaction.
- The non-matching completion in BUSY (write_complete during a read, or data_valid during a write) is ignored and not routed.
- Any completion pulse in IDLE is ignored and not routed.
- Reset while BUSY: the transaction is abandoned and the request drops on the reset edge. A late completion arriving afterwards falls in IDLE and is ignored.
- Only one master is ever granted; grant is never 11.

Optional Feature:
- Macro DRAM_ARB_ROUND_ROBIN_EN.
- Defined: when both masters request in IDLE, the master != last_owner wins. A single requester always wins regardless of last_owner.
- Undefined: fixed priority; master 0 always wins ties, and last_owner is unused (it may be optimised away).

Test Plan:
- Single read: m0 read at addr 0x000123; DRAM model returns 0xdeadbeef with data_valid 8 cycles later → dram_req_read high from edge after request until the completion edge. dram_addr = 0x000123 throughout. m0_data_valid is a 1-cycle pulse with m0_data_in = 0xdeadbeef. m1_data_valid stays 0.
- Single write: m1 writes 0xcafef00d to 0x00f00d; write_complete after 3 cycles → dram_req_write, dram_data_out = 0xcafef00d held. m1_write_complete pulses once. grant = 10 then 00.
- Contention: m0 and m1 both assert writes on the same edge and re-request immediately after each completion.
  - With DRAM_ARB_ROUND_ROBIN_EN: grant sequence 01, 10, 01, 10, with ≥1 IDLE cycle between each.
  - Without it: m0 is granted every time while it keeps requesting.
- Parameter hold: while m0 is BUSY, change m0_addr and m0_data_out and raise m1_req_read → dram outputs and grant unchanged until completion. m1 is granted on the edge after the IDLE cycle.
- Spurious and mismatched completions: a data_valid pulse in IDLE, and a data_valid pulse during a write → no mN pulse, no state change. The write still completes only on write_complete.
- Reset mid-transaction: drive rst = 0 for one edge while m1 read is BUSY, then raise data_valid 2 cycles later → all outputs at reset values after that edge. m1_data_valid never pulses.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter
//    Two-master arbiter in front of the single DRAM controller request port.
//    Master 0 is the CPU/cache fill path and master 1 is the DMA engine.
//    Only one transaction is outstanding at a time. The winner's address,
//    data and direction are latched at grant and held until the matching
//    completion. The completion pulse is routed back to the owner only.
//
//    Ports:
//       clk, rst                    system clock, synchronous active-low reset
//       mN_addr / mN_data_out       master N address and write data
//       mN_req_read / mN_req_write  master N level requests (read wins if both)
//       mN_data_in                  read data to master N (unqualified)
//       mN_data_valid               read-complete pulse to master N
//       mN_write_complete           write-complete pulse to master N
//       dram_addr / dram_data_out   latched address and write data
//       dram_req_read/_write        request level to the DRAM controller
//       dram_data_in                read data from the DRAM controller
//       dram_data_valid             read-complete pulse from the controller
//       dram_write_complete         write-complete pulse from the controller
//       grant                       one-hot owner, 00 when idle
//       arb_busy                    high while a transaction is outstanding
//
//    Build option: DRAM_ARB_ROUND_ROBIN_EN
//       defined   - on a tie, the master that did not win last time wins
//       undefined - fixed priority, master 0 wins every tie
//
//    state | meaning
//    ------+--------------------------------------------------------------
//    IDLE  | no owner, DRAM requests low, waiting for any master request
//    BUSY  | owner/is_read latched, request held until matching completion

module dram_arbiter #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_data_out,
   input  logic                  m0_req_read,
   input  logic                  m0_req_write,
   output logic [DATA_WIDTH-1:0] m0_data_in,
   output logic                  m0_data_valid,
   output logic                  m0_write_complete,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_data_out,
   input  logic                  m1_req_read,
   input  logic                  m1_req_write,
   output logic [DATA_WIDTH-1:0] m1_data_in,
   output logic                  m1_data_valid,
   output logic                  m1_write_complete,
   output logic [ADDR_WIDTH-1:0] dram_addr,
   output logic [DATA_WIDTH-1:0] dram_data_out,
   output logic                  dram_req_read,
   output logic                  dram_req_write,
   input  logic [DATA_WIDTH-1:0] dram_data_in,
   input  logic                  dram_data_valid,
   input  logic                  dram_write_complete,
   output logic [1:0]            grant,
   output logic                  arb_busy
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state;
   state_t state_next;
   logic   owner;
   logic   is_read;
   logic   m0_req;
   logic   m1_req;
   logic   winner;
   logic   win_read;
   logic   done;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
   logic   last_owner;
`endif

   always_comb begin
      state_next = state;
      m0_req     = m0_req_read | m0_req_write;
      m1_req     = m1_req_read | m1_req_write;
      winner     = 1'b0;
      win_read   = 1'b0;
      done       = 1'b0;

      if (m0_req && m1_req) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
         winner = ~last_owner;
`else
         winner = 1'b0;
`endif
      end else begin
         winner = m1_req;
      end

      // read takes precedence when a master raises both requests
      win_read = winner ? m1_req_read : m0_req_read;

      // only the completion matching the latched direction ends the transaction
      done = is_read ? dram_data_valid : dram_write_complete;

      case (state)
         IDLE: if (m0_req || m1_req) state_next = BUSY;
         BUSY: if (done)             state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         owner         <= 1'b0;
         is_read       <= 1'b0;
         dram_addr     <= '0;
         dram_data_out <= '0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
         last_owner    <= 1'b1;
`endif
      end else begin
         state <= state_next;
         if (state == IDLE && state_next == BUSY) begin
            owner         <= winner;
            is_read       <= win_read;
            dram_addr     <= winner ? m1_addr : m0_addr;
            dram_data_out <= winner ? m1_data_out : m0_data_out;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
            last_owner    <= winner;
`endif
         end
      end
   end

   // request levels and grant derive from registered state only
   assign arb_busy       = (state == BUSY);
   assign dram_req_read  = arb_busy & is_read;
   assign dram_req_write = arb_busy & ~is_read;
   assign grant          = arb_busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

   assign m0_data_valid     = dram_data_valid     &  is_read & arb_busy & ~owner;
   assign m1_data_valid     = dram_data_valid     &  is_read & arb_busy &  owner;
   assign m0_write_complete = dram_write_complete & ~is_read & arb_busy & ~owner;
   assign m1_write_complete = dram_write_complete & ~is_read & arb_busy &  owner;

   // masters qualify read data with their own data_valid
   assign m0_data_in = dram_data_in;
   assign m1_data_in = dram_data_in;

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

   logic        clk;
   logic        rst;
   logic [23:0] m0_addr, m1_addr;
   logic [31:0] m0_data_out, m1_data_out;
   logic        m0_req_read, m0_req_write, m1_req_read, m1_req_write;
   logic [31:0] m0_data_in, m1_data_in;
   logic        m0_data_valid, m0_write_complete, m1_data_valid, m1_write_complete;
   logic [23:0] dram_addr;
   logic [31:0] dram_data_out;
   logic        dram_req_read, dram_req_write;
   logic [31:0] dram_data_in;
   logic        dram_data_valid, dram_write_complete;
   logic [1:0]  grant;
   logic        arb_busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          master;
      bit          rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   dram_arbiter dut (
      .clk                (clk),
      .rst                (rst),
      .m0_addr            (m0_addr),
      .m0_data_out        (m0_data_out),
      .m0_req_read        (m0_req_read),
      .m0_req_write       (m0_req_write),
      .m0_data_in         (m0_data_in),
      .m0_data_valid      (m0_data_valid),
      .m0_write_complete  (m0_write_complete),
      .m1_addr            (m1_addr),
      .m1_data_out        (m1_data_out),
      .m1_req_read        (m1_req_read),
      .m1_req_write       (m1_req_write),
      .m1_data_in         (m1_data_in),
      .m1_data_valid      (m1_data_valid),
      .m1_write_complete  (m1_write_complete),
      .dram_addr          (dram_addr),
      .dram_data_out      (dram_data_out),
      .dram_req_read      (dram_req_read),
      .dram_req_write     (dram_req_write),
      .dram_data_in       (dram_data_in),
      .dram_data_valid    (dram_data_valid),
      .dram_write_complete(dram_write_complete),
      .grant              (grant),
      .arb_busy           (arb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // inputs change 1 time unit after the active edge
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic complete(input bit rd, input logic [31:0] d);
      dram_data_in = d;
      if (rd) dram_data_valid = 1'b1;
      else    dram_write_complete = 1'b1;
      cycle();
      dram_data_valid     = 1'b0;
      dram_write_complete = 1'b0;
   endtask

   task automatic check_idle(input string name);
      chk({name, "_grant"}, grant, 2'b00);
      chk({name, "_busy"}, arb_busy, 1'b0);
      chk({name, "_req"}, {dram_req_read, dram_req_write}, 2'b00);
   endtask

   // monitor: every routed completion pulse must match the oldest expectation
   always @(negedge clk) begin : monitor
      logic [3:0] pulses;
      logic [3:0] exp_p;
      exp_t       e;
      pulses = {m1_write_complete, m1_data_valid, m0_write_complete, m0_data_valid};
      if (pulses != 4'b0000) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", pulses, 4'b0000);
         end else begin
            e = sb.pop_front();
            if (e.master == 1) exp_p = e.rd ? 4'b0100 : 4'b1000;
            else               exp_p = e.rd ? 4'b0001 : 4'b0010;
            chk("completion_route", pulses, exp_p);
            if (e.rd) chk("read_data", (e.master == 1) ? m1_data_in : m0_data_in, e.data);
         end
      end
   end

   initial begin
      logic [1:0] exp_g;
      rst = 1'b0;
      m0_addr = '0; m1_addr = '0; m0_data_out = '0; m1_data_out = '0;
      m0_req_read = 0; m0_req_write = 0; m1_req_read = 0; m1_req_write = 0;
      dram_data_in = '0; dram_data_valid = 0; dram_write_complete = 0;
      cycle();
      cycle();
      check_idle("reset");
      chk("reset_addr", dram_addr, 24'h0);
      chk("reset_data", dram_data_out, 32'h0);
      rst = 1'b1;

      // single read by m0
      m0_addr = 24'h000123;
      m0_req_read = 1'b1;
      cycle();
      chk("rd_grant", grant, 2'b01);
      chk("rd_busy", arb_busy, 1'b1);
      chk("rd_req", {dram_req_read, dram_req_write}, 2'b10);
      sb.push_back('{0, 1'b1, 32'hdeadbeef});
      for (int i = 0; i < 7; i++) begin
         cycle();
         chk("rd_hold_addr", dram_addr, 24'h000123);
         chk("rd_hold_req", dram_req_read, 1'b1);
      end
      complete(1'b1, 32'hdeadbeef);
      m0_req_read = 1'b0;
      check_idle("rd_done");

      // single write by m1
      m1_addr = 24'h00f00d;
      m1_data_out = 32'hcafef00d;
      m1_req_write = 1'b1;
      cycle();
      chk("wr_grant", grant, 2'b10);
      chk("wr_req", {dram_req_read, dram_req_write}, 2'b01);
      chk("wr_data", dram_data_out, 32'hcafef00d);
      chk("wr_addr", dram_addr, 24'h00f00d);
      sb.push_back('{1, 1'b0, 32'h0});
      cycle();
      cycle();
      chk("wr_hold_data", dram_data_out, 32'hcafef00d);
      complete(1'b0, 32'h0);
      m1_req_write = 1'b0;
      check_idle("wr_done");

      // contention: both masters keep writing
      m0_addr = 24'h0000a0; m0_data_out = 32'ha0a0a0a0;
      m1_addr = 24'h0000b0; m1_data_out = 32'hb0b0b0b0;
      m0_req_write = 1'b1;
      m1_req_write = 1'b1;
      for (int r = 0; r < 4; r++) begin
         cycle();
         exp_g = 2'b01;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
         exp_g = (r % 2 == 1) ? 2'b10 : 2'b01;
`endif
         chk("cont_grant", grant, exp_g);
         chk("cont_data", dram_data_out, (exp_g == 2'b01) ? 32'ha0a0a0a0 : 32'hb0b0b0b0);
         sb.push_back('{(exp_g == 2'b10) ? 1 : 0, 1'b0, 32'h0});
         complete(1'b0, 32'h0);
         chk("cont_idle_grant", grant, 2'b00);
      end
      m0_req_write = 1'b0;
      m1_req_write = 1'b0;
      cycle();
      check_idle("cont_done");

      // parameter hold while m0 owns the port
      m0_addr = 24'h000111; m0_data_out = 32'h11111111;
      m0_req_read = 1'b1;
      cycle();
      chk("hold_grant0", grant, 2'b01);
      m0_addr = 24'h000222; m0_data_out = 32'h22222222;
      m0_req_read = 1'b0;
      m1_addr = 24'h000333; m1_req_read = 1'b1;
      cycle();
      cycle();
      chk("hold_addr", dram_addr, 24'h000111);
      chk("hold_data", dram_data_out, 32'h11111111);
      chk("hold_grant", grant, 2'b01);
      chk("hold_req", {dram_req_read, dram_req_write}, 2'b10);
      sb.push_back('{0, 1'b1, 32'habcd0001});
      complete(1'b1, 32'habcd0001);
      check_idle("hold_gap");
      cycle();
      chk("hold_m1_grant", grant, 2'b10);
      chk("hold_m1_addr", dram_addr, 24'h000333);
      sb.push_back('{1, 1'b1, 32'h55aa55aa});
      complete(1'b1, 32'h55aa55aa);
      m1_req_read = 1'b0;
      check_idle("hold_done");

      // spurious completion in IDLE, mismatched completion during a write
      complete(1'b1, 32'h99999999);
      check_idle("spur_idle");
      m0_addr = 24'h000077; m0_data_out = 32'h12345678;
      m0_req_write = 1'b1;
      cycle();
      chk("mis_grant", grant, 2'b01);
      sb.push_back('{0, 1'b0, 32'h0});
      complete(1'b1, 32'h88888888);
      chk("mis_busy", arb_busy, 1'b1);
      chk("mis_req", {dram_req_read, dram_req_write}, 2'b01);
      complete(1'b0, 32'h0);
      m0_req_write = 1'b0;
      check_idle("mis_done");

      // reset while m1 read is outstanding
      m1_addr = 24'h000444; m1_data_out = 32'h44444444;
      m1_req_read = 1'b1;
      cycle();
      chk("rst_pre_grant", grant, 2'b10);
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      m1_req_read = 1'b0;
      check_idle("rst_mid");
      chk("rst_mid_addr", dram_addr, 24'h0);
      chk("rst_mid_data", dram_data_out, 32'h0);
      cycle();
      complete(1'b1, 32'h77777777);
      check_idle("rst_late");

      cycle();
      cycle();
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
